// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier (MULT / MULTU) producing a 2*WIDTH product into HI/LO.
// Latency: accept edge E0, WIDTH RUN edges, one FIX edge; done and new hi/lo visible after E(WIDTH+1).
// Backpressure: busy stalls the upstream pipeline registers; start is only honoured in IDLE.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start, op       request and opcode (01 = MULTU, 10 = MULT, others = no-op)
//   flush           synchronous abort of an in-flight multiply (beats start in IDLE)
//   src_a, src_b    multiplicand (rs) and multiplier (rt), only sampled at accept
//   busy            registered, high whenever the FSM is not IDLE
//   done            one-cycle pulse in the cycle hi/lo carry a new product
//   hi, lo          upper and lower product words, feed the MFHI/MFLO forwarding path

module seq_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             flush,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0]       OP_MULTU = 2'b01;
  localparam logic [1:0]       OP_MULT  = 2'b10;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  // Product / multiplier register: upper half accumulates partial sums,
  // lower half starts as the multiplier and is shifted out one bit per edge.
  logic [2*WIDTH-1:0] p;
  logic [WIDTH-1:0]   mcand;
  logic               neg;

  logic               op_signed;
  logic               op_valid;
  logic               accept;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] p_fixed;

  assign op_signed = (op == OP_MULT);
  assign op_valid  = (op == OP_MULTU) || op_signed;

  // flush in IDLE suppresses a simultaneous request.
  assign accept = (state == IDLE) && start && !flush && op_valid;

  // Signed operands are reduced to magnitudes so the datapath is purely
  // unsigned. The most negative value negates to itself, which read as
  // unsigned is exactly its magnitude, so no special case is needed.
  assign mag_a = (op_signed && src_a[WIDTH-1]) ? (~src_a + WIDTH'(1)) : src_a;
  assign mag_b = (op_signed && src_b[WIDTH-1]) ? (~src_b + WIDTH'(1)) : src_b;

  // One extra bit keeps the carry out of the partial sum; it becomes the
  // new MSB of p after the right shift.
  assign sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, mcand} : '0);

  // Sign restoration over the full product width.
  assign p_fixed = neg ? (~p + (2*WIDTH)'(1)) : p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      p     <= '0;
      mcand <= '0;
      neg   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            mcand <= mag_a;
            p     <= {{WIDTH{1'b0}}, mag_b};
            neg   <= op_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end
        end

        RUN: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            p   <= {sum, p[WIDTH-1:1]};
            cnt <= cnt + CNT_W'(1);
            // cnt still holds the pre-increment value, so this is the
            // WIDTH-th shift-add edge.
            if (cnt == LAST_CNT) begin
              state <= FIX;
            end
          end
        end

        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          // An abort here must leave the architectural HI/LO untouched.
          if (!flush) begin
            hi   <= p_fixed[2*WIDTH-1:WIDTH];
            lo   <= p_fixed[WIDTH-1:0];
            done <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Randomized and directed self-checking bench for seq_multiplier.
// Latency: checks 33 busy cycles per multiply and a single done pulse.
// Backpressure: exercises ignored requests, flush in RUN/FIX/IDLE and async reset.

module tb_seq_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic        flush;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_hilo;

  seq_multiplier #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .flush (flush),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  // Reference: plain integer multiplication at 64-bit precision.
  function automatic logic [63:0] ref_mul(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa;
    longint sb;
    if (o == 2'b10) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Issue one request and observe a fixed 40-cycle window after acceptance.
  // kind 0: plain; 1: extra MULT 2x2 request at cycle ic; 2: flush at cycle ic.
  task automatic run_mul(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int kind, input int ic,
                         input int exp_busy, input int exp_done, input logic [63:0] want);
    int bc = 0;
    int dc = 0;
    int dpos = 0;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 2'($urandom);
    src_a = $urandom;
    src_b = $urandom;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin
        dc++;
        dpos = c;
      end
      start = 1'b0;
      flush = 1'b0;
      if (kind == 1 && c == ic) begin
        start = 1'b1; op = 2'b10; src_a = 32'd2; src_b = 32'd2;
      end
      if (kind == 2 && c == ic) flush = 1'b1;
    end
    check({tag, "_busy_cycles"}, 64'(bc), 64'(exp_busy));
    check({tag, "_done_count"}, 64'(dc), 64'(exp_done));
    if (exp_done == 1) check({tag, "_done_cycle"}, 64'(dpos), 64'd34);
    check({tag, "_hilo"}, {hi, lo}, want);
    exp_hilo = want;
  endtask

  // A request that must not start anything.
  task automatic idle_poke(input string tag, input logic [1:0] o, input logic fl);
    @(negedge clk);
    start = 1'b1; op = o; flush = fl; src_a = $urandom; src_b = $urandom;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd0);
    @(negedge clk);
    check({tag, "_busy2"}, 64'(busy), 64'd0);
    check({tag, "_hilo"}, {hi, lo}, exp_hilo);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    rst = 1'b1; start = 1'b0; op = 2'b00; flush = 1'b0; src_a = '0; src_b = '0;
    exp_hilo = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 64'(busy), 64'd0);

    run_mul("multu_3x5", 2'b01, 32'd3, 32'd5, 0, 0, 33, 1, 64'h0000_0000_0000_000F);
    run_mul("flush_run", 2'b01, 32'd100, 32'd100, 2, 10, 10, 0, 64'h0000_0000_0000_000F);
    run_mul("multu_100", 2'b01, 32'd100, 32'd100, 0, 0, 33, 1, 64'd10000);
    run_mul("multu_ones", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 33, 1,
            64'hFFFF_FFFE_0000_0001);
    run_mul("mult_m1m1", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 33, 1, 64'd1);
    run_mul("mult_m1x2", 2'b10, 32'hFFFF_FFFF, 32'd2, 0, 0, 33, 1, 64'hFFFF_FFFF_FFFF_FFFE);
    run_mul("mult_min_sq", 2'b10, 32'h8000_0000, 32'h8000_0000, 0, 0, 33, 1,
            64'h4000_0000_0000_0000);
    run_mul("mult_min_x1", 2'b10, 32'h8000_0000, 32'd1, 0, 0, 33, 1, 64'hFFFF_FFFF_8000_0000);
    run_mul("ignored_start", 2'b01, 32'd7, 32'd9, 1, 5, 33, 1, 64'd63);

    idle_poke("op00", 2'b00, 1'b0);
    idle_poke("op11", 2'b11, 1'b0);
    idle_poke("flush_idle", 2'b01, 1'b1);

    // Flush while the FSM sits in FIX: no write, no done.
    run_mul("flush_fix", 2'b01, $urandom, $urandom, 2, 33, 33, 0, exp_hilo);

    for (int i = 0; i < 20; i++) begin
      ro = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      ra = $urandom;
      rb = $urandom;
      if (i % 5 == 0) ra = 32'h8000_0000;
      if (i % 7 == 0) rb = 32'h0;
      run_mul($sformatf("rand%0d", i), ro, ra, rb, 0, 0, 33, 1, ref_mul(ro, ra, rb));
    end

    // Asynchronous reset between edges in the middle of a MULT.
    @(negedge clk);
    start = 1'b1; op = 2'b10; src_a = $urandom; src_b = $urandom;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_hilo = '0;
    run_mul("multu_6x7", 2'b01, 32'd6, 32'd7, 0, 0, 33, 1, 64'd42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    bad++;
    $display("FAIL timeout: got=running want=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
